// File: rtl/os_assembler.sv
// rtl/os_assembler.sv - frames TS1/TS2 ordered sets, flags idle, SKP, EIOS and framing errors
module os_assembler #(
  parameter logic [7:0] COM_SYM = 8'hBC,
  parameter logic [7:0] SKP_SYM = 8'h1C,
  parameter logic [7:0] IDL_SYM = 8'h7C,
  parameter logic [7:0] PAD_SYM = 8'hF7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [7:0]   symbol,
  input  logic         symbol_k,
  input  logic         symbol_valid,
  output logic [127:0] orderedset,
  output logic         valid,
  output logic         skp_detected,
  output logic         eios_detected,
  output logic         os_error
);

  typedef enum logic [2:0] {
    S_HUNT,
    S_TYPE,
    S_COLLECT,
    S_SKP,
    S_EIOS
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     index_q, index_d;
  logic [1:0]     count_q, count_d;
  logic [127:0]   shadow_q, shadow_d;
  logic [127:0]   orderedset_q, orderedset_d;
  logic           valid_q, valid_d;
  logic           skp_q, skp_d;
  logic           eios_q, eios_d;
  logic           err_q, err_d;

  logic           is_com;
  assign is_com = symbol_k && (symbol == COM_SYM);

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    count_d      = count_q;
    shadow_d     = shadow_q;
    orderedset_d = orderedset_q;
    valid_d      = 1'b0;
    skp_d        = 1'b0;
    eios_d       = 1'b0;
    err_d        = 1'b0;

    if (!enable) begin
      state_d = S_HUNT;
      index_d = 4'd0;
      count_d = 2'd0;
    end else if (symbol_valid) begin
      case (state_q)
        S_HUNT: begin
          if (is_com) begin
            shadow_d[7:0] = COM_SYM;
            state_d       = S_TYPE;
          end else if (!symbol_k && symbol == 8'h00) begin
            orderedset_d = '0;
            valid_d      = 1'b1;
          end
        end

        S_TYPE: begin
          if (symbol_k && symbol == SKP_SYM) begin
            state_d = S_SKP;
            count_d = 2'd1;
          end else if (symbol_k && symbol == IDL_SYM) begin
            state_d = S_EIOS;
            count_d = 2'd1;
          end else if (is_com) begin
            // Back-to-back COM: treat the newest one as the start of the set.
            err_d = 1'b1;
          end else if (!symbol_k || symbol == PAD_SYM) begin
            shadow_d[15:8] = symbol;
            index_d        = 4'd2;
            state_d        = S_COLLECT;
          end else begin
            err_d   = 1'b1;
            state_d = S_HUNT;
          end
        end

        S_COLLECT: begin
          if (symbol_k && !(index_q == 4'd2 && symbol == PAD_SYM)) begin
            err_d   = 1'b1;
            index_d = 4'd0;
            state_d = is_com ? S_TYPE : S_HUNT;
          end else if (index_q >= 4'd11 && symbol != shadow_q[87:80]) begin
            err_d   = 1'b1;
            index_d = 4'd0;
            state_d = S_HUNT;
          end else begin
            shadow_d[{index_q, 3'b000} +: 8] = symbol;
            if (index_q == 4'd15) begin
              orderedset_d = {symbol, shadow_q[119:0]};
              valid_d      = 1'b1;
              index_d      = 4'd0;
              state_d      = S_HUNT;
            end else begin
              index_d = index_q + 4'd1;
            end
          end
        end

        S_SKP, S_EIOS: begin
          // count tracks matching symbols seen so far, including symbol 1.
          if (symbol_k && symbol == ((state_q == S_SKP) ? SKP_SYM : IDL_SYM)) begin
            if (count_q == 2'd2) begin
              skp_d   = (state_q == S_SKP);
              eios_d  = (state_q == S_EIOS);
              count_d = 2'd0;
              state_d = S_HUNT;
            end else begin
              count_d = count_q + 2'd1;
            end
          end else begin
            err_d   = 1'b1;
            count_d = 2'd0;
            state_d = is_com ? S_TYPE : S_HUNT;
          end
        end

        default: begin
          state_d = S_HUNT;
          index_d = 4'd0;
          count_d = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_HUNT;
      index_q      <= 4'd0;
      count_q      <= 2'd0;
      shadow_q     <= '0;
      orderedset_q <= '0;
      valid_q      <= 1'b0;
      skp_q        <= 1'b0;
      eios_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      count_q      <= count_d;
      shadow_q     <= shadow_d;
      orderedset_q <= orderedset_d;
      valid_q      <= valid_d;
      skp_q        <= skp_d;
      eios_q       <= eios_d;
      err_q        <= err_d;
    end
  end

  assign orderedset    = orderedset_q;
  assign valid         = valid_q;
  assign skp_detected  = skp_q;
  assign eios_detected = eios_q;
  assign os_error      = err_q;

endmodule

// File: tb/tb_os_assembler.sv
// tb/tb_os_assembler.sv - directed-vector bench for os_assembler
module tb_os_assembler;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [7:0]   symbol;
  logic         symbol_k;
  logic         symbol_valid;
  logic [127:0] orderedset;
  logic         valid;
  logic         skp_detected;
  logic         eios_detected;
  logic         os_error;

  int vec_cnt = 0;
  int miscmp_cnt = 0;
  int n_valid, n_skp, n_eios, n_err;

  logic [7:0] ts_b [16];
  logic       ts_k [16];

  os_assembler dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .symbol        (symbol),
    .symbol_k      (symbol_k),
    .symbol_valid  (symbol_valid),
    .orderedset    (orderedset),
    .valid         (valid),
    .skp_detected  (skp_detected),
    .eios_detected (eios_detected),
    .os_error      (os_error)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive one symbol, let one edge capture it, then tally the pulses it produced.
  task automatic send(input logic [7:0] s, input logic k, input logic v);
    symbol       = s;
    symbol_k     = k;
    symbol_valid = v;
    @(posedge clk);
    #1;
    n_valid += int'(valid);
    n_skp   += int'(skp_detected);
    n_eios  += int'(eios_detected);
    n_err   += int'(os_error);
    symbol_valid = 1'b0;
  endtask

  task automatic clear_counts();
    n_valid = 0;
    n_skp   = 0;
    n_eios  = 0;
    n_err   = 0;
  endtask

  task automatic load_ts1();
    ts_b[0] = 8'hBC; ts_k[0] = 1'b1;
    ts_b[1] = 8'hF7; ts_k[1] = 1'b1;
    ts_b[2] = 8'hF7; ts_k[2] = 1'b1;
    ts_b[3] = 8'h0F; ts_k[3] = 1'b0;
    ts_b[4] = 8'h02; ts_k[4] = 1'b0;
    for (int i = 5; i < 10; i++) begin ts_b[i] = 8'h00; ts_k[i] = 1'b0; end
    for (int i = 10; i < 16; i++) begin ts_b[i] = 8'h2A; ts_k[i] = 1'b0; end
  endtask

  task automatic load_ts2();
    ts_b[0] = 8'hBC; ts_k[0] = 1'b1;
    ts_b[1] = 8'h01; ts_k[1] = 1'b0;
    ts_b[2] = 8'h00; ts_k[2] = 1'b0;
    ts_b[3] = 8'h0F; ts_k[3] = 1'b0;
    ts_b[4] = 8'h02; ts_k[4] = 1'b0;
    ts_b[5] = 8'h00; ts_k[5] = 1'b0;
    for (int i = 6; i < 16; i++) begin ts_b[i] = 8'h25; ts_k[i] = 1'b0; end
  endtask

  function automatic logic [127:0] pack_ts();
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = ts_b[i];
    return r;
  endfunction

  task automatic send_ts(input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      send(ts_b[i], ts_k[i], 1'b1);
      if (gaps && i < last) send(8'h00, 1'b0, 1'b0);
    end
  endtask

  logic [127:0] ts2_word;

  initial begin
    reset        = 1'b0;
    enable       = 1'b1;
    symbol       = 8'h00;
    symbol_k     = 1'b0;
    symbol_valid = 1'b0;
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    expect_eq("rst_os", orderedset, 128'h0);
    expect_eq("rst_valid", {127'h0, valid}, 128'h0);
    expect_eq("rst_skp", {127'h0, skp_detected}, 128'h0);
    expect_eq("rst_eios", {127'h0, eios_detected}, 128'h0);
    expect_eq("rst_err", {127'h0, os_error}, 128'h0);
    reset = 1'b1;

    // TS1 with PAD link/lane
    load_ts1();
    clear_counts();
    send_ts(0, 14, 1'b0);
    expect_eq("ts1_early_valid", 128'(n_valid), 128'd0);
    send(ts_b[15], ts_k[15], 1'b1);
    expect_eq("ts1_valid", {127'h0, valid}, 128'h1);
    expect_eq("ts1_os", orderedset, 128'h2A2A2A2A2A2A0000000000020FF7F7BC);
    expect_eq("ts1_err", 128'(n_err), 128'd0);
    send(8'h00, 1'b0, 1'b0);
    expect_eq("ts1_pulse_width", {127'h0, valid}, 128'h0);

    // TS2 with gaps
    load_ts2();
    ts2_word = pack_ts();
    clear_counts();
    send_ts(0, 15, 1'b1);
    expect_eq("ts2_valid", {127'h0, valid}, 128'h1);
    expect_eq("ts2_count", 128'(n_valid), 128'd1);
    expect_eq("ts2_os", orderedset, 128'h252525252525252525250002_0F0001BC);

    // SKP ordered set
    clear_counts();
    send(8'hBC, 1'b1, 1'b1);
    send(8'h1C, 1'b1, 1'b1);
    send(8'h1C, 1'b1, 1'b1);
    expect_eq("skp_early", 128'(n_skp), 128'd0);
    send(8'h1C, 1'b1, 1'b1);
    expect_eq("skp_pulse", {127'h0, skp_detected}, 128'h1);
    expect_eq("skp_no_valid", 128'(n_valid), 128'd0);
    expect_eq("skp_os_held", orderedset, ts2_word);

    // EIOS, then a broken EIOS
    clear_counts();
    send(8'hBC, 1'b1, 1'b1);
    send(8'h7C, 1'b1, 1'b1);
    send(8'h7C, 1'b1, 1'b1);
    send(8'h7C, 1'b1, 1'b1);
    expect_eq("eios_pulse", {127'h0, eios_detected}, 128'h1);
    send(8'hBC, 1'b1, 1'b1);
    send(8'h7C, 1'b1, 1'b1);
    send(8'h7C, 1'b1, 1'b1);
    send(8'h00, 1'b0, 1'b1);
    expect_eq("eios_bad_err", {127'h0, os_error}, 128'h1);
    expect_eq("eios_count", 128'(n_eios), 128'd1);
    send(8'h00, 1'b0, 1'b1);
    expect_eq("eios_bad_hunt_idle", {127'h0, valid}, 128'h1);
    expect_eq("eios_bad_hunt_os", orderedset, 128'h0);

    // COM injected at symbol 7, then resync body
    load_ts1();
    clear_counts();
    send_ts(0, 6, 1'b0);
    send(8'hBC, 1'b1, 1'b1);
    expect_eq("com7_err", {127'h0, os_error}, 128'h1);
    send_ts(1, 15, 1'b0);
    expect_eq("com7_valid", {127'h0, valid}, 128'h1);
    expect_eq("com7_count", 128'(n_valid), 128'd1);
    expect_eq("com7_os", orderedset, pack_ts());

    // Symbol 12 mismatches symbol 10
    ts_b[12] = 8'h2B;
    clear_counts();
    send_ts(0, 12, 1'b0);
    expect_eq("sym12_err", {127'h0, os_error}, 128'h1);
    send_ts(13, 15, 1'b0);
    expect_eq("sym12_no_valid", 128'(n_valid), 128'd0);
    expect_eq("sym12_err_count", 128'(n_err), 128'd1);

    // Logical idle run
    clear_counts();
    for (int i = 0; i < 8; i++) send(8'h00, 1'b0, 1'b1);
    expect_eq("idle_count", 128'(n_valid), 128'd8);
    expect_eq("idle_os", orderedset, 128'h0);

    // enable dropped mid-TS
    load_ts1();
    clear_counts();
    send_ts(0, 9, 1'b0);
    enable = 1'b0;
    send(ts_b[10], ts_k[10], 1'b1);
    enable = 1'b1;
    send_ts(11, 15, 1'b0);
    expect_eq("en_mid_valid", 128'(n_valid), 128'd0);
    expect_eq("en_mid_err", 128'(n_err), 128'd0);
    expect_eq("en_mid_os", orderedset, 128'h0);

    // enable falls with the final symbol
    clear_counts();
    send_ts(0, 14, 1'b0);
    enable = 1'b0;
    send(ts_b[15], ts_k[15], 1'b1);
    enable = 1'b1;
    expect_eq("en_final_valid", {127'h0, valid}, 128'h0);
    expect_eq("en_final_count", 128'(n_valid), 128'd0);
    send_ts(0, 15, 1'b0);
    expect_eq("en_after_valid", {127'h0, valid}, 128'h1);
    expect_eq("en_after_os", orderedset, pack_ts());

    // reset asserted mid-TS
    clear_counts();
    send_ts(0, 7, 1'b0);
    reset = 1'b0;
    #1;
    expect_eq("rst_mid_os", orderedset, 128'h0);
    expect_eq("rst_mid_valid", {127'h0, valid}, 128'h0);
    expect_eq("rst_mid_err", {127'h0, os_error}, 128'h0);
    #2;
    reset = 1'b1;
    send_ts(8, 15, 1'b0);
    expect_eq("rst_mid_idle_only", 128'(n_valid), 128'd2);
    expect_eq("rst_mid_os_after", orderedset, 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
